eth_sw_xbar: RTL



---
 rtl/eth_sw_pkg.sv | 18 +
 rtl/eth_sw_xbar_if.sv | 31 +++
 rtl/eth_rr_arbiter.sv | 46 ++++
 rtl/eth_sw_xbar.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_sw_pkg.sv
// Shared types and helpers for the N-port cut-through switch crossbar.
package eth_sw_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } ing_st_e;

   localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0010;
   localparam logic [31:0] CRC_GOOD_DEF  = 32'hDEAD_BEEF;

   // Round-robin pointer advance: one past the winner, wrapping at n.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
   endfunction

endpackage

// File: rtl/eth_sw_xbar_if.sv
// Ingress FIFO read side and egress tx side of the switch crossbar, flattened per port.
interface eth_sw_xbar_if #(
   parameter int unsigned N_PORTS = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned CRC_W   = 32
);
   logic [N_PORTS-1:0]        in_valid;
   logic [N_PORTS-1:0]        in_ready;
   logic [N_PORTS-1:0]        in_sop;
   logic [N_PORTS-1:0]        in_eop;
   logic [N_PORTS*ADDR_W-1:0] in_dest;
   logic [N_PORTS*CRC_W-1:0]  in_crc;
   logic [N_PORTS*DATA_W-1:0] in_data;
   logic [N_PORTS-1:0]        out_valid;
   logic [N_PORTS-1:0]        out_ready;
   logic [N_PORTS-1:0]        out_sop;
   logic [N_PORTS-1:0]        out_eop;
   logic [N_PORTS-1:0]        out_err;
   logic [N_PORTS*DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_sop, in_eop, in_dest, in_crc, in_data, out_ready,
      input  in_ready, out_valid, out_sop, out_eop, out_err, out_data
   );

   modport slave (
      input  in_valid, in_sop, in_eop, in_dest, in_crc, in_data, out_ready,
      output in_ready, out_valid, out_sop, out_eop, out_err, out_data
   );
endinterface

// File: rtl/eth_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant searched from ptr_q, pointer advances on a granted enable.
module eth_rr_arbiter
   import eth_sw_pkg::*;
#(
   parameter int unsigned N_PORTS = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [N_PORTS-1:0] req,
   input  logic               en,
   output logic [N_PORTS-1:0] gnt_c
);
   localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] win;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      gnt_c = '0;
      found = 1'b0;
      win   = ptr_q;
      idx   = ptr_q;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
         idx = PW'((32'(ptr_q) + k) % N_PORTS);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      if (en && found) begin
         gnt_c[win] = 1'b1;
      end
      ptr_d = (en && found) ? PW'(rr_next(32'(win), N_PORTS)) : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/eth_sw_xbar.sv
// N-port cut-through crossbar: per-ingress routing FSM, per-egress lock + output register.
module eth_sw_xbar
   import eth_sw_pkg::*;
#(
   parameter int unsigned       N_PORTS   = 4,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       CRC_W     = 32,
   parameter int unsigned       CNT_W     = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
   parameter logic [CRC_W-1:0]  CRC_GOOD  = CRC_W'(CRC_GOOD_DEF)
) (
   input  logic                     clk,
   input  logic                     rstn,
   eth_sw_xbar_if.slave             bus,
   output logic [N_PORTS*CNT_W-1:0] drop_cnt,
   output logic [N_PORTS*CNT_W-1:0] crc_err_cnt
);
   localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   ing_st_e            st_q   [N_PORTS];
   ing_st_e            st_d   [N_PORTS];
   logic [PW-1:0]      egr_q  [N_PORTS];
   logic [PW-1:0]      egr_d  [N_PORTS];
   logic [PW-1:0]      own_q  [N_PORTS];
   logic [PW-1:0]      own_d  [N_PORTS];
   logic [DATA_W-1:0]  odat_q [N_PORTS];
   logic [DATA_W-1:0]  odat_d [N_PORTS];
   logic [CNT_W-1:0]   drop_q [N_PORTS];
   logic [CNT_W-1:0]   drop_d [N_PORTS];
   logic [CNT_W-1:0]   crc_q  [N_PORTS];
   logic [CNT_W-1:0]   crc_d  [N_PORTS];
   logic [N_PORTS-1:0] lock_q, lock_d, ov_q, ov_d, osop_q, osop_d;
   logic [N_PORTS-1:0] oeop_q, oeop_d, oerr_q, oerr_d;

   logic [ADDR_W-1:0]  off [N_PORTS];
   logic [PW-1:0]      dix [N_PORTS];
   logic [PW-1:0]      tgt [N_PORTS];
   logic [N_PORTS-1:0] req [N_PORTS];
   logic [N_PORTS-1:0] gnt [N_PORTS];
   logic [N_PORTS-1:0] routable, bad_crc, load, arb_en, rdy, fwd, term;

   // Destination decode, egress load condition and arbitration requests.
   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         off[i]      = bus.in_dest[i*ADDR_W +: ADDR_W] - BASE_ADDR;
         routable[i] = (bus.in_dest[i*ADDR_W +: ADDR_W] >= BASE_ADDR) &&
                       (off[i] < ADDR_W'(N_PORTS));
         dix[i]      = off[i][PW-1:0];
         bad_crc[i]  = (bus.in_crc[i*CRC_W +: CRC_W] != CRC_GOOD);
      end
      for (int e = 0; e < N_PORTS; e++) begin
         load[e]   = !ov_q[e] || bus.out_ready[e];
         arb_en[e] = load[e] && !lock_q[e];
         for (int i = 0; i < N_PORTS; i++) begin
            req[e][i] = (st_q[i] == IDLE) && bus.in_valid[i] && bus.in_sop[i] &&
                        routable[i] && (dix[i] == PW'(e));
         end
      end
   end

   for (genvar g = 0; g < N_PORTS; g++) begin : g_port
      eth_rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
         .clk   (clk),
         .rstn  (rstn),
         .req   (req[g]),
         .en    (arb_en[g]),
         .gnt_c (gnt[g])
      );
      assign bus.out_data[g*DATA_W +: DATA_W] = odat_q[g];
      assign drop_cnt[g*CNT_W +: CNT_W]       = drop_q[g];
      assign crc_err_cnt[g*CNT_W +: CNT_W]    = crc_q[g];
   end

   // Ingress consume decision; a sop seen while forwarding cuts the open frame short.
   always_comb begin
      logic g_any;
      for (int i = 0; i < N_PORTS; i++) begin
         g_any = 1'b0;
         for (int e = 0; e < N_PORTS; e++) begin
            g_any = g_any | gnt[e][i];
         end
         term[i] = (st_q[i] == FWD) && bus.in_sop[i];
         tgt[i]  = (st_q[i] == FWD) ? egr_q[i] : dix[i];
         case (st_q[i])
            IDLE:    rdy[i] = bus.in_valid[i] && (!bus.in_sop[i] || !routable[i] || g_any);
            FWD:     rdy[i] = bus.in_valid[i] && load[egr_q[i]];
            default: rdy[i] = bus.in_valid[i];
         endcase
         fwd[i] = rdy[i] && ((st_q[i] == FWD) ||
                             ((st_q[i] == IDLE) && bus.in_sop[i] && routable[i]));
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = ov_q;
   assign bus.out_sop   = osop_q;
   assign bus.out_eop   = oeop_q;
   assign bus.out_err   = oerr_q;

   // Egress output registers and lock ownership.
   always_comb begin
      lock_d = lock_q;
      ov_d   = ov_q;
      osop_d = osop_q;
      oeop_d = oeop_q;
      oerr_d = oerr_q;
      for (int e = 0; e < N_PORTS; e++) begin
         own_d[e]  = own_q[e];
         odat_d[e] = odat_q[e];
      end
      for (int e = 0; e < N_PORTS; e++) begin
         if (load[e]) begin
            ov_d[e]   = 1'b0;
            osop_d[e] = 1'b0;
            oeop_d[e] = 1'b0;
            oerr_d[e] = 1'b0;
         end
         for (int i = 0; i < N_PORTS; i++) begin
            if (fwd[i] && (tgt[i] == PW'(e))) begin
               ov_d[e]   = 1'b1;
               osop_d[e] = bus.in_sop[i];
               oeop_d[e] = bus.in_eop[i] | term[i];
               oerr_d[e] = term[i] | (bus.in_eop[i] & bad_crc[i]);
               odat_d[e] = bus.in_data[i*DATA_W +: DATA_W];
            end
         end
         if (!lock_q[e]) begin
            for (int i = 0; i < N_PORTS; i++) begin
               if (gnt[e][i] && !bus.in_eop[i]) begin
                  lock_d[e] = 1'b1;
                  own_d[e]  = PW'(i);
               end
            end
         end else if (fwd[own_q[e]] && (bus.in_eop[own_q[e]] || bus.in_sop[own_q[e]])) begin
            lock_d[e] = 1'b0;
         end
      end
   end

   // Ingress FSM next state and saturating statistics.
   always_comb begin
      logic dinc;
      logic cinc;
      for (int i = 0; i < N_PORTS; i++) begin
         st_d[i]  = st_q[i];
         egr_d[i] = egr_q[i];
         dinc     = 1'b0;
         cinc     = 1'b0;
         if (rdy[i]) begin
            case (st_q[i])
               IDLE: begin
                  if (!bus.in_sop[i]) begin
                     dinc = 1'b1;
                  end else if (!routable[i]) begin
                     dinc = 1'b1;
                     if (!bus.in_eop[i]) st_d[i] = DROP;
                  end else if (bus.in_eop[i]) begin
                     cinc = bad_crc[i];
                  end else begin
                     st_d[i]  = FWD;
                     egr_d[i] = dix[i];
                  end
               end
               FWD: begin
                  if (bus.in_sop[i]) begin
                     dinc    = 1'b1;
                     st_d[i] = IDLE;
                  end else if (bus.in_eop[i]) begin
                     cinc    = bad_crc[i];
                     st_d[i] = IDLE;
                  end
               end
               default: begin
                  if (bus.in_eop[i]) st_d[i] = IDLE;
               end
            endcase
         end
         drop_d[i] = (dinc && (drop_q[i] != '1)) ? drop_q[i] + CNT_W'(1) : drop_q[i];
         crc_d[i]  = (cinc && (crc_q[i] != '1)) ? crc_q[i] + CNT_W'(1) : crc_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         lock_q <= '0;
         ov_q   <= '0;
         osop_q <= '0;
         oeop_q <= '0;
         oerr_q <= '0;
         for (int i = 0; i < N_PORTS; i++) begin
            st_q[i]   <= IDLE;
            egr_q[i]  <= '0;
            own_q[i]  <= '0;
            odat_q[i] <= '0;
            drop_q[i] <= '0;
            crc_q[i]  <= '0;
         end
      end else begin
         lock_q <= lock_d;
         ov_q   <= ov_d;
         osop_q <= osop_d;
         oeop_q <= oeop_d;
         oerr_q <= oerr_d;
         for (int i = 0; i < N_PORTS; i++) begin
            st_q[i]   <= st_d[i];
            egr_q[i]  <= egr_d[i];
            own_q[i]  <= own_d[i];
            odat_q[i] <= odat_d[i];
            drop_q[i] <= drop_d[i];
            crc_q[i]  <= crc_d[i];
         end
      end
   end

endmodule
